// File: rtl/core_pkg.sv
// Shared core definitions: architectural register file geometry and address type.
package core_pkg;
    localparam int XLEN          = 32;
    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_AW        = $clog2(NUM_ARCH_REGS);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module rf_scoreboard
    import core_pkg::*;
#(
    parameter  int NREGS = NUM_ARCH_REGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    // Callers qualify set_en/clr_en with address legality, so the decode never goes out of range.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_addr] = 1'b1;
        if (clr_en) clr_vec[clr_addr] = 1'b1;
    end

    // OR-ing the set after the clear lets a newer issue win over a same-cycle writeback.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_vec) | set_vec;
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Parametrised register file: NR combinational read ports, one write port,
// optional write-to-read bypass and a pending-write scoreboard for RAW detection.
module regfile_bypass_sb
    import core_pkg::*;
#(
    parameter  int DW       = XLEN,
    parameter  int NREGS    = NUM_ARCH_REGS,
    parameter  int NR       = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == AW'(REG_ZERO)));
    endfunction

    logic [DW-1:0]    mem [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_ok;
    logic             iss_ok;

    assign wr_ok  = we && addr_ok(waddr);
    assign iss_ok = issue_valid && addr_ok(issue_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_ok),
        .set_addr (issue_rd),
        .clr_en   (wr_ok),
        .clr_addr (waddr),
        .busy     (busy)
    );

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [AW-1:0] idx;
        logic          ok;
        logic          hit;

        assign ra  = raddr[i*AW +: AW];
        assign ok  = addr_ok(ra);
        assign idx = ok ? ra : '0;
        // A forwarded value is current data, so it must not also be flagged busy.
        assign hit = (BYPASS != 0) && wr_ok && (waddr == ra);

        assign rdata[i*DW +: DW] = (rst || !ok) ? '0 : (hit ? wdata : mem[idx]);
        assign rbusy[i]          = !rst && ok && busy[idx] && !hit;
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: a 32-reg/2-port bypassing file and a 24-reg/4-port
// non-bypassing file share one stimulus stream and are checked against a behavioural model.
module tb_regfile_bypass_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [4*AW-1:0] raddr;
    logic           issue_valid;
    logic [AW-1:0]  issue_rd;

    logic [2*DW-1:0] rdata0;
    logic [1:0]      rbusy0;
    logic [4*DW-1:0] rdata1;
    logic [3:0]      rbusy1;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: cfg 0 = 32 regs, bypass; cfg 1 = 24 regs, no bypass.
    logic [DW-1:0] m0 [32];
    logic [DW-1:0] m1 [24];
    bit            b0 [32];
    bit            b1 [24];

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DW(32), .NREGS(32), .NR(2), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr[2*AW-1:0]),
        .rdata       (rdata0),
        .rbusy       (rbusy0),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd)
    );

    regfile_bypass_sb #(.DW(32), .NREGS(24), .NR(4), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr       (raddr),
        .rdata       (rdata1),
        .rbusy       (rbusy1),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int a, input int nregs);
        return (a != 0) && (a < nregs);
    endfunction

    function automatic logic [DW-1:0] model_data(input int cfg, input int a);
        int nregs = (cfg == 0) ? 32 : 24;
        bit fwd   = (cfg == 0) && we && legal(int'(waddr), nregs) && (int'(waddr) == a);
        if (rst || !legal(a, nregs)) return '0;
        if (fwd) return wdata;
        return (cfg == 0) ? m0[a] : m1[a];
    endfunction

    function automatic bit model_busy(input int cfg, input int a);
        int nregs = (cfg == 0) ? 32 : 24;
        bit fwd   = (cfg == 0) && we && legal(int'(waddr), nregs) && (int'(waddr) == a);
        if (rst || !legal(a, nregs)) return 1'b0;
        return ((cfg == 0) ? b0[a] : b1[a]) && !fwd;
    endfunction

    task automatic model_check();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("d0_rd%0d", p), rdata0[p*DW +: DW], model_data(0, int'(raddr[p*AW +: AW])));
            chk($sformatf("d0_bz%0d", p), 32'(rbusy0[p]), 32'(model_busy(0, int'(raddr[p*AW +: AW]))));
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("d1_rd%0d", p), rdata1[p*DW +: DW], model_data(1, int'(raddr[p*AW +: AW])));
            chk($sformatf("d1_bz%0d", p), 32'(rbusy1[p]), 32'(model_busy(1, int'(raddr[p*AW +: AW]))));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin m0[r] = '0; b0[r] = 1'b0; end
            for (int r = 0; r < 24; r++) begin m1[r] = '0; b1[r] = 1'b0; end
        end else begin
            if (we && legal(int'(waddr), 32)) begin m0[waddr] = wdata; b0[waddr] = 1'b0; end
            if (we && legal(int'(waddr), 24)) begin m1[waddr] = wdata; b1[waddr] = 1'b0; end
            if (issue_valid && legal(int'(issue_rd), 32)) b0[issue_rd] = 1'b1;
            if (issue_valid && legal(int'(issue_rd), 24)) b1[issue_rd] = 1'b1;
        end
    endtask

    // Inputs are stable at this point; check mid-cycle, then advance one edge.
    task automatic do_cycle();
        #2;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic idle();
        we          = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        issue_valid = 1'b0; issue_rd = '0;
        for (int r = 0; r < 32; r++) begin m0[r] = '0; b0[r] = 1'b0; end
        for (int r = 0; r < 24; r++) begin m1[r] = '0; b1[r] = 1'b0; end
        do_cycle();
        rst = 1'b0;
        do_cycle();

        // Reset discards stored data and busy state.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        do_cycle();
        we = 1'b0; rst = 1'b1; set_rd(0, 5'd5); set_rd(1, 5'd5);
        issue_valid = 1'b1; issue_rd = 5'd5;
        #2;
        chk("rst_hold_rd", rdata0[31:0], 32'h0);
        chk("rst_hold_bz", 32'(rbusy0), 32'h0);
        do_cycle();
        rst = 1'b0; issue_valid = 1'b0;
        #2;
        chk("rst_r5_p0", rdata0[31:0], 32'h0);
        chk("rst_r5_p1", rdata0[63:32], 32'h0);
        do_cycle();

        // Write then read, with and without bypass.
        we = 1'b1; waddr = 5'd7; wdata = 32'h14; set_rd(0, 5'd7);
        #2;
        chk("byp_same", rdata0[31:0], 32'h14);
        chk("nobyp_same", rdata1[31:0], 32'h0);
        do_cycle();
        idle();
        #2;
        chk("byp_next", rdata0[31:0], 32'h14);
        chk("nobyp_next", rdata1[31:0], 32'h14);
        do_cycle();

        // Register 0 is hard-wired.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_rd(0, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        #2;
        chk("r0_wr_same", rdata0[31:0], 32'h0);
        do_cycle();
        idle();
        #2;
        chk("r0_rd", rdata0[31:0], 32'h0);
        chk("r0_busy", 32'(rbusy0[0]), 32'h0);
        do_cycle();

        // Scoreboard set, set-wins collision, then clear.
        issue_valid = 1'b1; issue_rd = 5'd3; set_rd(0, 5'd3);
        do_cycle();
        issue_valid = 1'b0;
        #2;
        chk("sb_set", 32'(rbusy0[0]), 32'h1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h55; issue_valid = 1'b1; issue_rd = 5'd3;
        #2;
        chk("sb_fwd_nbz", 32'(rbusy0[0]), 32'h0);
        chk("sb_nofwd_bz", 32'(rbusy1[0]), 32'h1);
        do_cycle();
        idle();
        #2;
        chk("sb_setwins", 32'(rbusy0[0]), 32'h1);
        chk("sb_r3_55", rdata0[31:0], 32'h55);
        do_cycle();
        we = 1'b1; waddr = 5'd3; wdata = 32'h66;
        #2;
        chk("sb_old_55", rdata1[31:0], 32'h55);
        chk("sb_fwd_66", rdata0[31:0], 32'h66);
        do_cycle();
        idle();
        #2;
        chk("sb_clear", 32'(rbusy0[0]), 32'h0);
        chk("sb_r3_66", rdata1[31:0], 32'h66);
        do_cycle();

        // Top register of the 24-entry file and an out-of-range address.
        we = 1'b1; waddr = 5'd23; wdata = 32'hA5A5A5A5;
        do_cycle();
        idle();
        for (int p = 0; p < 4; p++) set_rd(p, 5'd23);
        #2;
        for (int p = 0; p < 4; p++) chk($sformatf("r23_p%0d", p), rdata1[p*DW +: DW], 32'hA5A5A5A5);
        do_cycle();
        we = 1'b1; waddr = 5'd30; wdata = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd30;
        do_cycle();
        idle();
        for (int p = 0; p < 4; p++) set_rd(p, 5'd30);
        #2;
        for (int p = 0; p < 4; p++) chk($sformatf("r30_p%0d", p), rdata1[p*DW +: DW], 32'h0);
        chk("r30_busy", 32'(rbusy1), 32'h0);
        chk("r30_big", rdata0[31:0], 32'h1234);
        do_cycle();

        // Random back-to-back traffic, reads biased toward the write address.
        for (int c = 0; c < 10000; c++) begin
            rst         = ($urandom_range(0, 255) == 0);
            we          = $urandom_range(0, 1) != 0;
            waddr       = AW'($urandom_range(0, 31));
            wdata       = $urandom;
            issue_valid = $urandom_range(0, 2) != 0;
            issue_rd    = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++)
                set_rd(p, ($urandom_range(0, 1) != 0) ? waddr : AW'($urandom_range(0, 31)));
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
